cordic_out_buffer: RTL

Output buffer and flow-control stage directly downstream of the 16-stage CORDIC pipeline. The CORDIC pipeline cannot stall, so this block does two things:
- captures every `valid_out`/`cos_out`/`sin_out` beat into a FIFO and presents the samples to the consumer with a ready/valid handshake;
- tracks samples still in flight in the pipeline and tells the upstream theta source when a new issue is guaranteed to find a free slot.

Together these give lossless back-pressure across a pipeline that has none.

---
 rtl/cordic_pkg.sv | 13 +
 rtl/cordic_out_buffer_if.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/cordic_out_buffer.sv | 86 ++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC datapath and its output buffer.
package cordic_pkg;

    typedef logic [15:0] short_t;

    typedef struct packed {
        short_t cos;
        short_t sin;
    } sample_t;

    localparam int unsigned CORDIC_LATENCY = 16;

endpackage

// File: rtl/cordic_out_buffer_if.sv
// Stream signals between the CORDIC pipeline, the theta source, the buffer and the consumer.
interface cordic_out_buffer_if;
    import cordic_pkg::*;

    logic   issue_in;
    logic   issue_ok;
    logic   valid_in;
    short_t cos_in;
    short_t sin_in;
    logic   valid_out;
    logic   ready_in;
    short_t cos_out;
    short_t sin_out;

    modport slave (
        input  issue_in, valid_in, cos_in, sin_in, ready_in,
        output issue_ok, valid_out, cos_out, sin_out
    );

    modport master (
        output issue_in, valid_in, cos_in, sin_in, ready_in,
        input  issue_ok, valid_out, cos_out, sin_out
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; read data is zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign rd_en = pop && !empty;
    // A write at full is legal only when the same edge frees the head slot.
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wptr_q] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/cordic_out_buffer.sv
// Lossless buffer behind the non-stalling CORDIC pipeline: captures every result beat and
// grants issue credit only when a free FIFO slot is guaranteed for the result.
module cordic_out_buffer
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cordic_out_buffer_if.slave   bus,
    output logic [CW-1:0]        count,
    output logic                 overflow,
    output logic                 proto_err
);

    localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
    localparam logic [CW:0]   DepthSum = (CW + 1)'(DEPTH);

    sample_t       wdata, head;
    logic          push, pop, full, empty;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW:0]   credit_used;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;

    assign wdata.cos = bus.cos_in;
    assign wdata.sin = bus.sin_in;

    assign pop  = bus.valid_out && bus.ready_in;
    assign push = bus.valid_in && (!full || pop);

    sync_fifo #(
        .WIDTH ($bits(sample_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.valid_out = !empty;
    assign bus.cos_out   = head.cos;
    assign bus.sin_out   = head.sin;

    // Credit depends on registered state only, so issue_ok has no input-to-output path.
    assign credit_used  = {1'b0, count} + {1'b0, inflight_q};
    assign bus.issue_ok = (credit_used < DepthSum);

    always_comb begin
        inflight_d  = inflight_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        if (bus.issue_in && !bus.valid_in) begin
            if (inflight_q != DepthC) inflight_d = inflight_q + 1'b1;
        end else if (!bus.issue_in && bus.valid_in) begin
            if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
        end
        if (bus.valid_in && full && !pop) overflow_d = 1'b1;
        if ((bus.valid_in && (inflight_q == '0)) || (bus.issue_in && !bus.issue_ok)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q  <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule
